// File: rtl/bids22_settle.sv
// bids22_settle: settles auction rounds against a three-bidder ledger.
//
// Each round is marked by a rising edge on roundOver. The winner flags,
// winning bid and error code are classified. A valid win is debited from
// the winner's balance. A settlement record is then queued in a small
// FIFO for a downstream consumer.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   roundOver                    round strobe (0->1 edge starts a round)
//   X_win, Y_win, Z_win          winner flags
//   maxBid [31:0], err [2:0]     winning amount, upstream error (3'b101 = duplicate)
//   ld_valid, ld_sel, ld_value   balance load (only honoured while idle)
//   X/Y/Z_balance [31:0]         ledger balances
//   rec_valid/rec_ready          record handshake
//   rec_winner, rec_amount,
//   rec_code, rec_round          FIFO head record fields
//   busy                         settlement in progress
//   overflow                     sticky: a round or a record was dropped
module bids22_settle #(
  parameter int FIFO_DEPTH = 4,
  parameter int ROUND_W    = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               roundOver,
  input  logic               X_win,
  input  logic               Y_win,
  input  logic               Z_win,
  input  logic [31:0]        maxBid,
  input  logic [2:0]         err,
  input  logic               ld_valid,
  input  logic [1:0]         ld_sel,
  input  logic [31:0]        ld_value,
  output logic [31:0]        X_balance,
  output logic [31:0]        Y_balance,
  output logic [31:0]        Z_balance,
  output logic               rec_valid,
  input  logic               rec_ready,
  output logic [1:0]         rec_winner,
  output logic [31:0]        rec_amount,
  output logic [1:0]         rec_code,
  output logic [ROUND_W-1:0] rec_round,
  output logic               busy,
  output logic               overflow
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int REC_W = 2 + 32 + 2 + ROUND_W;

  localparam logic [1:0] CODE_OK    = 2'b00;
  localparam logic [1:0] CODE_NONE  = 2'b01;
  localparam logic [1:0] CODE_MULTI = 2'b10;
  localparam logic [1:0] CODE_FUNDS = 2'b11;
  localparam logic [1:0] WIN_NONE   = 2'b11;

  typedef enum logic [1:0] {IDLE, CHECK, DEBIT, POST} state_t;

  state_t state, state_nx;

  // Edge detect and one-deep pending round buffer
  logic        ro_q;
  logic        rise;
  logic        pending;
  logic        cap_x, cap_y, cap_z;
  logic [31:0] cap_bid;
  logic [2:0]  cap_err;
  logic        round_drop;

  // Balances and settlement result
  logic [31:0] x_bal, y_bal, z_bal;
  logic [1:0]  res_winner;
  logic [31:0] res_amount;
  logic [1:0]  res_code;
  logic [1:0]  cls_winner;
  logic [31:0] cls_amount;
  logic [1:0]  cls_code;
  logic [31:0] cls_bal;
  logic [ROUND_W-1:0] round_cnt;

  // Record FIFO
  logic [REC_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             fifo_full, fifo_empty;
  logic             pop, push, rec_drop;
  logic [REC_W-1:0] head;

  assign rise       = roundOver & ~ro_q;
  // A round arriving while one is already buffered is lost
  assign round_drop = rise & pending;

  assign count      = wr_ptr - rd_ptr;
  assign fifo_full  = count[AW];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign pop        = ~fifo_empty & rec_ready;
  // Full FIFO still accepts a push when the head leaves in the same cycle
  assign push       = (state == POST) & (~fifo_full | pop);
  assign rec_drop   = (state == POST) & fifo_full & ~pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // An edge seen in IDLE goes straight to CHECK so the captured round is
  // classified the following cycle; pending only holds rounds that arrive
  // while a settlement is already in flight.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (pending || rise) state_nx = CHECK;
      CHECK:   state_nx = DEBIT;
      DEBIT:   state_nx = POST;
      POST:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ro_q    <= 1'b0;
      pending <= 1'b0;
      cap_x   <= 1'b0;
      cap_y   <= 1'b0;
      cap_z   <= 1'b0;
      cap_bid <= '0;
      cap_err <= '0;
    end else begin
      ro_q <= roundOver;
      if (rise && !pending) begin
        cap_x   <= X_win;
        cap_y   <= Y_win;
        cap_z   <= Z_win;
        cap_bid <= maxBid;
        cap_err <= err;
      end
      if (state == IDLE) pending <= 1'b0;
      else if (rise)     pending <= 1'b1;
    end
  end

  always_comb begin
    cls_bal = z_bal;
    if (cap_x)      cls_bal = x_bal;
    else if (cap_y) cls_bal = y_bal;
  end

  always_comb begin
    cls_winner = WIN_NONE;
    cls_amount = '0;
    cls_code   = CODE_NONE;
    if (cap_err != 3'b101 && (cap_x | cap_y | cap_z)) begin
      if ((cap_x & cap_y) | (cap_x & cap_z) | (cap_y & cap_z)) begin
        cls_code = CODE_MULTI;
      end else begin
        cls_winner = cap_x ? 2'b00 : (cap_y ? 2'b01 : 2'b10);
        if (cap_bid > cls_bal) begin
          cls_code = CODE_FUNDS;
        end else begin
          cls_code   = CODE_OK;
          cls_amount = cap_bid;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_winner <= WIN_NONE;
      res_amount <= '0;
      res_code   <= CODE_NONE;
    end else if (state == CHECK) begin
      res_winner <= cls_winner;
      res_amount <= cls_amount;
      res_code   <= cls_code;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_bal <= '0;
      y_bal <= '0;
      z_bal <= '0;
    end else if (state == IDLE && ld_valid) begin
      unique case (ld_sel)
        2'b00:   x_bal <= ld_value;
        2'b01:   y_bal <= ld_value;
        2'b10:   z_bal <= ld_value;
        default: ;
      endcase
    end else if (state == DEBIT && res_code == CODE_OK) begin
      unique case (res_winner)
        2'b00:   x_bal <= x_bal - res_amount;
        2'b01:   y_bal <= y_bal - res_amount;
        2'b10:   z_bal <= z_bal - res_amount;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      round_cnt <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
    end else begin
      if (state == POST) round_cnt <= round_cnt + 1'b1;
      if (push)          wr_ptr    <= wr_ptr + 1'b1;
      if (pop)           rd_ptr    <= rd_ptr + 1'b1;
      if (round_drop || rec_drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {res_winner, res_amount, res_code, round_cnt};
  end

  assign head = mem[rd_ptr[AW-1:0]];

  always_comb begin
    rec_winner = WIN_NONE;
    rec_amount = '0;
    rec_code   = CODE_NONE;
    rec_round  = '0;
    if (!fifo_empty) {rec_winner, rec_amount, rec_code, rec_round} = head;
  end

  assign rec_valid = ~fifo_empty;
  assign busy      = (state != IDLE);
  assign X_balance = x_bal;
  assign Y_balance = y_bal;
  assign Z_balance = z_bal;

endmodule
